// File: rtl/jtcps1_prog_sched_if.sv
// Bus bundle for jtcps1_prog_sched: loader-side write strobe and fields,
// SDRAM programming port, and download status flags.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface jtcps1_prog_sched_if;
  logic        downloading;
  logic        in_we;
  logic [21:0] in_addr;
  logic [7:0]  in_data;
  logic [1:0]  in_mask;
  logic [1:0]  in_bank;
  logic        dwnld_busy;
  logic        prog_we;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        sdram_ack;
  logic        dwnld_done;
  logic        overflow;
  logic        ack_err;

  modport slave (
    input  downloading, in_we, in_addr, in_data, in_mask, in_bank, sdram_ack,
    output dwnld_busy, prog_we, prog_addr, prog_data, prog_mask, prog_bank,
           dwnld_done, overflow, ack_err
  );

  modport master (
    output downloading, in_we, in_addr, in_data, in_mask, in_bank, sdram_ack,
    input  dwnld_busy, prog_we, prog_addr, prog_data, prog_mask, prog_bank,
           dwnld_done, overflow, ack_err
  );
endinterface

// File: rtl/jtcps1_prog_sched.sv
// jtcps1_prog_sched: queues ROM-download byte writes in a FIFO and issues
// them to the SDRAM programming port with a prog_we/sdram_ack handshake.
// Optional feature macro: JTCPS1_PROG_MERGE_EN -- merges two queued byte
// writes to the same word (complementary masks) into one 16-bit write.
module jtcps1_prog_sched #(
  parameter int DEPTH  = 16,
  parameter int ACK_TO = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  jtcps1_prog_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TO + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] BUSY_C = CW'(DEPTH - 2);
  localparam logic [TW-1:0] TO_MAX = TW'(ACK_TO);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        state_r, state_nxt_s;
  logic [21:0]   addr_mem_r [DEPTH];
  logic [7:0]    data_mem_r [DEPTH];
  logic [1:0]    mask_mem_r [DEPTH];
  logic [1:0]    bank_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s, pop_n_s;
  logic [TW-1:0] to_cnt_r, to_cnt_nxt_s;
  logic          dl_prev_r, done_armed_r, pop2_r;
  logic          prog_we_r, busy_r, done_r, overflow_r, ack_err_r;
  logic [21:0]   prog_addr_r;
  logic [15:0]   prog_data_r;
  logic [1:0]    prog_mask_r, prog_bank_r;
  logic          full_s, push_s, dl_rise_s, merge_s, load_s, ack_s, done_s;
  logic [15:0]   ld_data_s;
  logic [1:0]    ld_mask_s;

  assign full_s    = (count_r == FULL_C);
  assign push_s    = bus.in_we && !full_s;
  assign dl_rise_s = bus.downloading && !dl_prev_r;

`ifdef JTCPS1_PROG_MERGE_EN
  logic [AW-1:0] nxt_ptr_s;
  assign nxt_ptr_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
  // Head and next entry form one word when address/bank match and masks complement
  always_comb begin
    merge_s = 1'b0;
    if ((count_r >= CW'(2)) &&
        (addr_mem_r[rd_ptr_r] == addr_mem_r[nxt_ptr_s]) &&
        (bank_mem_r[rd_ptr_r] == bank_mem_r[nxt_ptr_s]) &&
        (((mask_mem_r[rd_ptr_r] == 2'b10) && (mask_mem_r[nxt_ptr_s] == 2'b01)) ||
         ((mask_mem_r[rd_ptr_r] == 2'b01) && (mask_mem_r[nxt_ptr_s] == 2'b10)))) begin
      merge_s = 1'b1;
    end else begin
      merge_s = 1'b0;
    end
  end
`else
  assign merge_s = 1'b0;
`endif

  // Data and mask presented for the next issued write
  always_comb begin
    ld_data_s = {data_mem_r[rd_ptr_r], data_mem_r[rd_ptr_r]};
    ld_mask_s = mask_mem_r[rd_ptr_r];
`ifdef JTCPS1_PROG_MERGE_EN
    if (merge_s) begin
      ld_mask_s = 2'b00;
      if (mask_mem_r[rd_ptr_r] == 2'b10) begin
        ld_data_s = {data_mem_r[nxt_ptr_s], data_mem_r[rd_ptr_r]};
      end else begin
        ld_data_s = {data_mem_r[rd_ptr_r], data_mem_r[nxt_ptr_s]};
      end
    end else begin
      ld_mask_s = mask_mem_r[rd_ptr_r];
    end
`endif
  end

  // Next-state and control strobes of the issue FSM
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    ack_s       = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != {CW{1'b0}}) begin
          load_s      = 1'b1;
          state_nxt_s = ST_WAIT;
        end else if (!bus.downloading && done_armed_r) begin
          done_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.sdram_ack) begin
          ack_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO occupancy bookkeeping; a merged write retires two entries
  always_comb begin
    if (ack_s) begin
      pop_n_s = pop2_r ? CW'(2) : CW'(1);
    end else begin
      pop_n_s = {CW{1'b0}};
    end
    count_nxt_s = count_r + CW'(push_s) - pop_n_s;
  end

  // Timeout counter runs only while a request waits, saturating at ACK_TO
  always_comb begin
    to_cnt_nxt_s = to_cnt_r;
    if (dl_rise_s || load_s) begin
      to_cnt_nxt_s = {TW{1'b0}};
    end else if ((state_r == ST_WAIT) && !bus.sdram_ack && (to_cnt_r != TO_MAX)) begin
      to_cnt_nxt_s = to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_nxt_s = to_cnt_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FIFO storage; contents are qualified by count_r so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= bus.in_addr;
      data_mem_r[wr_ptr_r] <= bus.in_data;
      mask_mem_r[wr_ptr_r] <= bus.in_mask;
      bank_mem_r[wr_ptr_r] <= bus.in_bank;
    end
  end

  // FIFO pointers, occupancy and the loader stall flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      rd_ptr_r <= rd_ptr_r + pop_n_s[AW-1:0];
      count_r  <= count_nxt_s;
      busy_r   <= (count_nxt_s >= BUSY_C);
    end
  end

  // Issued write registers: loaded from the head, held until acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_we_r   <= 1'b0;
      prog_addr_r <= 22'd0;
      prog_data_r <= 16'd0;
      prog_mask_r <= 2'b00;
      prog_bank_r <= 2'b00;
      pop2_r      <= 1'b0;
    end else if (load_s) begin
      prog_we_r   <= 1'b1;
      prog_addr_r <= addr_mem_r[rd_ptr_r];
      prog_data_r <= ld_data_s;
      prog_mask_r <= ld_mask_s;
      prog_bank_r <= bank_mem_r[rd_ptr_r];
      pop2_r      <= merge_s;
    end else if (ack_s) begin
      prog_we_r   <= 1'b0;
    end
  end

  // Download tracking, end-of-download pulse and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_prev_r    <= 1'b0;
      done_armed_r <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      ack_err_r    <= 1'b0;
      to_cnt_r     <= {TW{1'b0}};
    end else begin
      dl_prev_r <= bus.downloading;
      done_r    <= done_s;
      to_cnt_r  <= to_cnt_nxt_s;
      if (dl_rise_s)   done_armed_r <= 1'b1;
      else if (done_s) done_armed_r <= 1'b0;
      if (bus.in_we && full_s) overflow_r <= 1'b1;
      else if (dl_rise_s)      overflow_r <= 1'b0;
      if (dl_rise_s) ack_err_r <= 1'b0;
      else if ((state_r == ST_WAIT) && (to_cnt_nxt_s == TO_MAX)) ack_err_r <= 1'b1;
    end
  end

  assign bus.prog_we    = prog_we_r;
  assign bus.prog_addr  = prog_addr_r;
  assign bus.prog_data  = prog_data_r;
  assign bus.prog_mask  = prog_mask_r;
  assign bus.prog_bank  = prog_bank_r;
  assign bus.dwnld_busy = busy_r;
  assign bus.dwnld_done = done_r;
  assign bus.overflow   = overflow_r;
  assign bus.ack_err    = ack_err_r;
endmodule

// File: tb/tb_jtcps1_prog_sched.sv
// Directed self-checking bench for jtcps1_prog_sched (DEPTH=16, ACK_TO=1023).
module tb_jtcps1_prog_sched;
  localparam int ACK_TO = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clk = ~clk;

  jtcps1_prog_sched_if bus();

  jtcps1_prog_sched #(.DEPTH(16), .ACK_TO(ACK_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [21:0] a, input logic [7:0] d,
                      input logic [1:0] m, input logic [1:0] b);
    bus.in_we   = 1'b1;
    bus.in_addr = a;
    bus.in_data = d;
    bus.in_mask = m;
    bus.in_bank = b;
    tick();
    bus.in_we   = 1'b0;
  endtask

  // bounded wait for a request; an expired bound shows up as a failed check
  task automatic wait_we(input string tag);
    int n = 0;
    while (bus.prog_we !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_we"}, 32'(bus.prog_we), 32'd1);
  endtask

  task automatic ack_write(input string tag, input logic [21:0] a, input logic [15:0] d,
                           input logic [1:0] m, input int dly);
    wait_we(tag);
    chk({tag, "_addr"}, 32'(bus.prog_addr), 32'(a));
    chk({tag, "_data"}, 32'(bus.prog_data), 32'(d));
    chk({tag, "_mask"}, 32'(bus.prog_mask), 32'(m));
    repeat (dly) tick();
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk({tag, "_we_low"}, 32'(bus.prog_we), 32'd0);
  endtask

  initial begin
    bus.downloading = 1'b0;
    bus.in_we       = 1'b0;
    bus.in_addr     = 22'd0;
    bus.in_data     = 8'd0;
    bus.in_mask     = 2'b00;
    bus.in_bank     = 2'b00;
    bus.sdram_ack   = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_we",   32'(bus.prog_we),    32'd0);
    chk("rst_busy", 32'(bus.dwnld_busy), 32'd0);
    chk("rst_done", 32'(bus.dwnld_done), 32'd0);
    chk("rst_ovf",  32'(bus.overflow),   32'd0);
    chk("rst_err",  32'(bus.ack_err),    32'd0);
    chk("rst_data", 32'(bus.prog_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // no download since reset: no done pulse
    pulses = 0;
    repeat (5) begin
      tick();
      if (bus.dwnld_done === 1'b1) pulses++;
    end
    chk("nodl_done", 32'(pulses), 32'd0);

    // 1: single write, 3-cycle ack latency
    bus.downloading = 1'b1;
    tick();
    push(22'h1234, 8'hA5, 2'b10, 2'b01);
    chk("t1_we_n", 32'(bus.prog_we), 32'd0);
    tick();
    chk("t1_we",   32'(bus.prog_we),   32'd1);
    chk("t1_addr", 32'(bus.prog_addr), 32'h1234);
    chk("t1_data", 32'(bus.prog_data), 32'hA5A5);
    chk("t1_mask", 32'(bus.prog_mask), 32'h2);
    chk("t1_bank", 32'(bus.prog_bank), 32'h1);
    repeat (3) tick();
    chk("t1_hold", 32'(bus.prog_we), 32'd1);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk("t1_we_low", 32'(bus.prog_we), 32'd0);
    chk("t1_count",  32'(dut.count_r), 32'd0);

    // 4: push and ack on the same edge with count=3
    push(22'h201, 8'h01, 2'b10, 2'b00);
    push(22'h202, 8'h02, 2'b10, 2'b00);
    push(22'h203, 8'h03, 2'b10, 2'b00);
    chk("t4_count3", 32'(dut.count_r), 32'd3);
    chk("t4_head",   32'(bus.prog_addr), 32'h201);
    bus.in_we     = 1'b1;
    bus.in_addr   = 22'h204;
    bus.in_data   = 8'h04;
    bus.sdram_ack = 1'b1;
    tick();
    bus.in_we     = 1'b0;
    bus.sdram_ack = 1'b0;
    chk("t4_count_same", 32'(dut.count_r), 32'd3);
    ack_write("t4_b", 22'h202, 16'h0202, 2'b10, 0);
    ack_write("t4_c", 22'h203, 16'h0303, 2'b10, 0);
    ack_write("t4_d", 22'h204, 16'h0404, 2'b10, 0);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    tick();
    chk("t4_stray_we",    32'(bus.prog_we), 32'd0);
    chk("t4_stray_count", 32'(dut.count_r), 32'd0);

    // 2: fill past DEPTH without acks
    for (int i = 0; i < 16; i++) begin
      push(22'h100 + 22'(i), 8'(i), 2'b10, 2'b10);
      if (i == 12) chk("t2_busy_lo", 32'(bus.dwnld_busy), 32'd0);
      if (i == 13) chk("t2_busy_hi", 32'(bus.dwnld_busy), 32'd1);
    end
    chk("t2_ovf0", 32'(bus.overflow), 32'd0);
    push(22'h1FF, 8'hFF, 2'b10, 2'b10);
    chk("t2_ovf1",  32'(bus.overflow), 32'd1);
    chk("t2_count", 32'(dut.count_r),  32'd16);
    for (int i = 0; i < 16; i++) begin
      ack_write($sformatf("t2_w%0d", i), 22'h100 + 22'(i), {8'(i), 8'(i)}, 2'b10, 0);
    end
    repeat (5) tick();
    chk("t2_no17", 32'(bus.prog_we), 32'd0);
    chk("t2_busy_end", 32'(bus.dwnld_busy), 32'd0);
    bus.downloading = 1'b0;
    repeat (4) tick();
    chk("t2_ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.downloading = 1'b1;
    tick();
    chk("t2_ovf_clr", 32'(bus.overflow), 32'd0);

    // 3: drop downloading with 5 queued, done after the last ack
    for (int i = 0; i < 5; i++) push(22'h300 + 22'(i), 8'h30 + 8'(i), 2'b01, 2'b00);
    bus.downloading = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ack_write($sformatf("t3_w%0d", i), 22'h300 + 22'(i),
                {8'h30 + 8'(i), 8'h30 + 8'(i)}, 2'b01, 2);
    end
    chk("t3_done_ack", 32'(bus.dwnld_done), 32'd0);
    tick();
    chk("t3_done", 32'(bus.dwnld_done), 32'd1);
    tick();
    chk("t3_done_end", 32'(bus.dwnld_done), 32'd0);
    pulses = 0;
    repeat (10) begin
      tick();
      if (bus.dwnld_done === 1'b1) pulses++;
    end
    chk("t3_no_second", 32'(pulses), 32'd0);

    // 5: ack timeout
    bus.downloading = 1'b1;
    tick();
    push(22'h400, 8'h5A, 2'b01, 2'b11);
    tick();
    chk("t5_we",   32'(bus.prog_we),   32'd1);
    chk("t5_data", 32'(bus.prog_data), 32'h5A5A);
    repeat (ACK_TO - 1) tick();
    chk("t5_err_pre", 32'(bus.ack_err), 32'd0);
    tick();
    chk("t5_err", 32'(bus.ack_err), 32'd1);
    repeat (4) tick();
    chk("t5_hold", 32'(bus.prog_we), 32'd1);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk("t5_late_ack",   32'(bus.prog_we), 32'd0);
    chk("t5_err_sticky", 32'(bus.ack_err), 32'd1);
    bus.downloading = 1'b0;
    repeat (3) tick();
    bus.downloading = 1'b1;
    tick();
    chk("t5_err_clr", 32'(bus.ack_err), 32'd0);

    // 6: byte pair to the same word, queued behind a pending write
    push(22'h03F, 8'h77, 2'b10, 2'b00);
    push(22'h010, 8'h11, 2'b10, 2'b00);
    push(22'h010, 8'h22, 2'b01, 2'b00);
    ack_write("t6_dummy", 22'h03F, 16'h7777, 2'b10, 0);
`ifdef JTCPS1_PROG_MERGE_EN
    ack_write("t6_merge", 22'h010, 16'h2211, 2'b00, 0);
`else
    ack_write("t6_lo", 22'h010, 16'h1111, 2'b10, 0);
    ack_write("t6_hi", 22'h010, 16'h2222, 2'b01, 0);
`endif
    repeat (5) tick();
    chk("t6_idle",  32'(bus.prog_we), 32'd0);
    chk("t6_count", 32'(dut.count_r), 32'd0);

    // 7: reset while waiting for an ack
    push(22'h500, 8'h50, 2'b10, 2'b00);
    push(22'h501, 8'h51, 2'b10, 2'b00);
    push(22'h502, 8'h52, 2'b10, 2'b00);
    chk("t7_wait", 32'(bus.prog_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_we",   32'(bus.prog_we),   32'd0);
    chk("t7_addr", 32'(bus.prog_addr), 32'd0);
    chk("t7_data", 32'(bus.prog_data), 32'd0);
    chk("t7_busy", 32'(bus.dwnld_busy), 32'd0);
    chk("t7_done", 32'(bus.dwnld_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t7_empty_we",    32'(bus.prog_we), 32'd0);
    chk("t7_empty_count", 32'(dut.count_r), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
